mioc_flop_bank_ctrl: RTL and testbench

Sequencing controller for a bank of WIDTH mioc flops (async reset, async set, D, falling-edge capture clock). Accepts one command at a time (clear, preset, load, read), drives the bank's async and clock pins with guaranteed pulse widths and setup/hold spacing, and reads back Q. It returns a verified snapshot with a mismatch flag and keeps a saturating error count. It sits between the MIOC register/command logic and the flop bank.

---
 rtl/mioc_flop_bank_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_mioc_flop_bank_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mioc_flop_bank_ctrl.sv
// Sequencing controller for a bank of mioc flops: drives the async and clock pins
// with fixed pulse widths, then samples Q and reports a checked snapshot.
module mioc_flop_bank_ctrl #(
    parameter int WIDTH     = 8,
    parameter int PULSE_CYC = 2
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_cmd_valid,
    output logic             o_cmd_ready,
    input  logic [1:0]       i_cmd_op,
    input  logic [WIDTH-1:0] i_cmd_data,
    output logic             o_rsp_valid,
    input  logic             i_rsp_ready,
    output logic [WIDTH-1:0] o_rsp_data,
    output logic             o_rsp_err,
    output logic [7:0]       o_err_cnt,
    output logic [WIDTH-1:0] o_fl_rst,
    output logic             o_fl_clk,
    output logic [WIDTH-1:0] o_fl_d,
    output logic [WIDTH-1:0] o_fl_set,
    input  logic [WIDTH-1:0] i_fl_q
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ASYNC,
        S_SETUP,
        S_FALL,
        S_RISE,
        S_VERIFY,
        S_RESP
    } state_t;

    localparam logic [1:0] OP_CLEAR  = 2'b00;
    localparam logic [1:0] OP_PRESET = 2'b01;
    localparam logic [1:0] OP_LOAD   = 2'b10;
    localparam logic [1:0] OP_READ   = 2'b11;

    localparam logic [3:0] PHASE_LOAD  = 4'(PULSE_CYC - 1);
    localparam logic [3:0] VERIFY_LOAD = 4'd1;

    state_t           r_state;
    state_t           w_stateNext;
    logic [3:0]       r_phase;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_data;
    logic             r_rspValid;
    logic [WIDTH-1:0] r_rspData;
    logic             r_rspErr;
    logic [7:0]       r_errCnt;
    logic [WIDTH-1:0] r_flRst;
    logic [WIDTH-1:0] r_flSet;
    logic [WIDTH-1:0] r_flD;
    logic             r_flClk;

    logic             w_accept;
    logic             w_phaseDone;
    logic             w_entering;
    logic             w_mismatch;
    logic             w_respond;
    logic [1:0]       w_op;
    logic [WIDTH-1:0] w_data;
    logic [WIDTH-1:0] w_flRstNext;
    logic [WIDTH-1:0] w_flSetNext;
    logic [WIDTH-1:0] w_flDNext;
    logic             w_flClkNext;

    assign w_accept    = (r_state == S_IDLE) && i_cmd_valid;
    assign w_phaseDone = (r_phase == 4'd0);
    assign w_entering  = (w_stateNext != r_state);
    assign w_respond   = (r_state == S_VERIFY) && (w_stateNext == S_RESP);
    assign w_op        = w_accept ? i_cmd_op : r_op;
    assign w_data      = w_accept ? i_cmd_data : r_data;

    // VERIFY spans two cycles: one settle cycle after the bank pins are released,
    // then Q is sampled on the edge that enters RESP.
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_cmd_valid) begin
                    case (i_cmd_op)
                        OP_LOAD: w_stateNext = S_SETUP;
                        OP_READ: w_stateNext = S_VERIFY;
                        default: w_stateNext = S_ASYNC;
                    endcase
                end
            end
            S_ASYNC:  if (w_phaseDone) w_stateNext = S_VERIFY;
            S_SETUP:  if (w_phaseDone) w_stateNext = S_FALL;
            S_FALL:   if (w_phaseDone) w_stateNext = S_RISE;
            S_RISE:   if (w_phaseDone) w_stateNext = S_VERIFY;
            S_VERIFY: if (w_phaseDone) w_stateNext = S_RESP;
            S_RESP:   if (i_rsp_ready) w_stateNext = S_IDLE;
            default:  w_stateNext = S_IDLE;
        endcase
    end

    always_comb begin
        w_mismatch = 1'b0;
        case (r_op)
            OP_CLEAR:  w_mismatch = |(i_fl_q & r_data);
            OP_PRESET: w_mismatch = |(~i_fl_q & r_data);
            OP_LOAD:   w_mismatch = (i_fl_q != r_data);
            default:   w_mismatch = 1'b0;
        endcase
    end

    // Pin values are computed from the upcoming state so each registered pin
    // changes on the same edge as the state it belongs to.
    always_comb begin
        w_flRstNext = '0;
        w_flSetNext = '0;
        w_flDNext   = '0;
        w_flClkNext = (w_stateNext != S_FALL);
        if (w_stateNext == S_ASYNC && w_op == OP_CLEAR) begin
            w_flRstNext = w_data;
        end
        if (w_stateNext == S_ASYNC && w_op == OP_PRESET) begin
            w_flSetNext = w_data;
        end
        if (w_op == OP_LOAD && (w_stateNext == S_SETUP || w_stateNext == S_FALL ||
                                w_stateNext == S_RISE  || w_stateNext == S_VERIFY)) begin
            w_flDNext = w_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_phase    <= 4'd0;
            r_op       <= OP_CLEAR;
            r_data     <= '0;
            r_rspValid <= 1'b0;
            r_rspData  <= '0;
            r_rspErr   <= 1'b0;
            r_errCnt   <= 8'd0;
            r_flRst    <= '1;
            r_flSet    <= '0;
            r_flD      <= '0;
            r_flClk    <= 1'b1;
        end else begin
            r_state <= w_stateNext;
            if (w_accept) begin
                r_op   <= i_cmd_op;
                r_data <= i_cmd_data;
            end
            if (w_entering) begin
                r_phase <= (w_stateNext == S_VERIFY) ? VERIFY_LOAD : PHASE_LOAD;
            end else if (!w_phaseDone) begin
                r_phase <= r_phase - 4'd1;
            end
            r_flRst <= w_flRstNext;
            r_flSet <= w_flSetNext;
            r_flD   <= w_flDNext;
            r_flClk <= w_flClkNext;
            if (w_respond) begin
                r_rspValid <= 1'b1;
                r_rspData  <= i_fl_q;
                r_rspErr   <= w_mismatch;
                if (w_mismatch && r_errCnt != 8'hFF) begin
                    r_errCnt <= r_errCnt + 8'd1;
                end
            end else if (r_state == S_RESP && i_rsp_ready) begin
                r_rspValid <= 1'b0;
            end
        end
    end

    assign o_cmd_ready = (r_state == S_IDLE);
    assign o_rsp_valid = r_rspValid;
    assign o_rsp_data  = r_rspData;
    assign o_rsp_err   = r_rspErr;
    assign o_err_cnt   = r_errCnt;
    assign o_fl_rst    = r_flRst;
    assign o_fl_set    = r_flSet;
    assign o_fl_d      = r_flD;
    assign o_fl_clk    = r_flClk;

endmodule

// File: tb/tb_mioc_flop_bank_ctrl.sv
// Bench for mioc_flop_bank_ctrl: behavioural flop bank, cycle-timed response model
// with a per-cycle compare process, and directed command sequences.
module tb_mioc_flop_bank_ctrl;

    localparam int WIDTH = 8;
    localparam int P     = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       cmdValid = 1'b0;
    logic       cmdReady;
    logic [1:0] cmdOp = 2'b00;
    logic [7:0] cmdData = 8'h00;
    logic       rspValid;
    logic       rspReady = 1'b1;
    logic [7:0] rspData;
    logic       rspErr;
    logic [7:0] errCnt;
    logic [7:0] flRst;
    logic       flClk;
    logic [7:0] flD;
    logic [7:0] flSet;
    logic [7:0] flQ;

    logic [7:0] bankQ = 8'h00;
    logic       prevClk = 1'b1;
    logic [7:0] stuck0 = 8'h00;

    int nCompared = 0;
    int nMismatched = 0;

    always #5 clk = ~clk;

    mioc_flop_bank_ctrl #(.WIDTH(WIDTH), .PULSE_CYC(P)) dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_cmd_valid (cmdValid),
        .o_cmd_ready (cmdReady),
        .i_cmd_op    (cmdOp),
        .i_cmd_data  (cmdData),
        .o_rsp_valid (rspValid),
        .i_rsp_ready (rspReady),
        .o_rsp_data  (rspData),
        .o_rsp_err   (rspErr),
        .o_err_cnt   (errCnt),
        .o_fl_rst    (flRst),
        .o_fl_clk    (flClk),
        .o_fl_d      (flD),
        .o_fl_set    (flSet),
        .i_fl_q      (flQ)
    );

    // Flop bank: capture D on the falling clock, async reset dominates async set.
    always @(flClk or flRst or flSet) begin
        if (prevClk === 1'b1 && flClk === 1'b0) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (!flRst[i] && !flSet[i]) bankQ[i] = flD[i];
            end
        end
        prevClk = flClk;
        bankQ = (bankQ | flSet) & ~flRst;
    end

    assign flQ = bankQ & ~stuck0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Expected behaviour: per-command response latency in edges after the accept edge.
    function automatic int rspLatency(input logic [1:0] op);
        case (op)
            2'b11:   return 2;
            2'b10:   return 3 * P + 2;
            default: return P + 2;
        endcase
    endfunction

    bit         mBusy = 1'b0;
    int         mK = 0;
    int         mRspK = 0;
    logic [1:0] mOp = 2'b00;
    logic [7:0] mData = 8'h00;
    logic [7:0] mBank = 8'h00;
    logic [7:0] mVis = 8'h00;
    logic [7:0] mRspData = 8'h00;
    bit         mRspErr = 1'b0;
    logic [7:0] mErrCnt = 8'h00;
    bit         mPostReset = 1'b1;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mBusy = 1'b0;
            mK = 0;
            mBank = 8'h00;
            mErrCnt = 8'h00;
            mPostReset = 1'b1;
        end else begin
            mPostReset = 1'b0;
            if (mBusy) begin
                if (mK >= mRspK && rspReady) begin
                    mBusy = 1'b0;
                end else begin
                    mK++;
                    if (mK == mRspK && mRspErr && mErrCnt != 8'hFF) mErrCnt++;
                end
            end else if (cmdValid) begin
                mBusy = 1'b1;
                mK = 0;
                mOp = cmdOp;
                mData = cmdData;
                mRspK = rspLatency(cmdOp);
                case (cmdOp)
                    2'b00:   mBank = mBank & ~cmdData;
                    2'b01:   mBank = mBank | cmdData;
                    2'b10:   mBank = cmdData;
                    default: mBank = mBank;
                endcase
                mVis = mBank & ~stuck0;
                mRspData = mVis;
                case (cmdOp)
                    2'b00:   mRspErr = |(mVis & cmdData);
                    2'b01:   mRspErr = |(~mVis & cmdData);
                    2'b10:   mRspErr = (mVis != cmdData);
                    default: mRspErr = 1'b0;
                endcase
            end
        end
    end

    logic [7:0] eFlRst, eFlSet, eFlD;
    logic       eFlClk, eRspValid;

    always @(negedge clk) begin
        eFlRst = mPostReset ? 8'hFF : ((mBusy && mOp == 2'b00 && mK < P) ? mData : 8'h00);
        eFlSet = (mBusy && mOp == 2'b01 && mK < P) ? mData : 8'h00;
        eFlClk = !(mBusy && mOp == 2'b10 && mK >= P && mK < 2 * P);
        eFlD   = (mBusy && mOp == 2'b10 && mK < 3 * P + 2) ? mData : 8'h00;
        eRspValid = mBusy && (mK >= mRspK);
        checkOutput("cmd_ready", 32'(cmdReady), 32'(!mBusy));
        checkOutput("fl_rst", 32'(flRst), 32'(eFlRst));
        checkOutput("fl_set", 32'(flSet), 32'(eFlSet));
        checkOutput("fl_clk", 32'(flClk), 32'(eFlClk));
        checkOutput("fl_d", 32'(flD), 32'(eFlD));
        checkOutput("rsp_valid", 32'(rspValid), 32'(eRspValid));
        checkOutput("err_cnt", 32'(errCnt), 32'(mErrCnt));
        if (eRspValid) begin
            checkOutput("rsp_data", 32'(rspData), 32'(mRspData));
            checkOutput("rsp_err", 32'(rspErr), 32'(mRspErr));
        end
    end

    // Issues one command and waits for its response; counts pin activity on the way.
    task automatic applyStimulus(input logic [1:0] op, input logic [7:0] data,
                                 output int lat, output logic [7:0] d, output logic e,
                                 output int clkLow, output int setCnt);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!cmdReady && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        cmdValid = 1'b1;
        cmdOp = op;
        cmdData = data;
        @(posedge clk);
        #1;
        cmdValid = 1'b0;
        cmdData = ~data;
        clkLow = flClk ? 0 : 1;
        setCnt = (flSet != 8'h00) ? 1 : 0;
        lat = 0;
        while (!rspValid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (!flClk) clkLow++;
            if (flSet != 8'h00) setCnt++;
        end
        if (!rspValid) checkOutput("rsp_timeout", 32'(rspValid), 'h1);
        d = rspData;
        e = rspErr;
        if (rspReady) begin
            @(posedge clk);
            #1;
        end
    endtask

    int         lat, clkLow, setCnt;
    logic [7:0] d, held;
    logic       e;

    initial begin
        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset_fl_rst", 32'(flRst), 'hFF);
        checkOutput("reset_fl_clk", 32'(flClk), 'h1);
        checkOutput("reset_cmd_ready", 32'(cmdReady), 'h1);
        checkOutput("reset_rsp_valid", 32'(rspValid), 'h0);
        checkOutput("reset_rsp_data", 32'(rspData), 'h0);
        checkOutput("reset_err_cnt", 32'(errCnt), 'h0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("release_fl_rst", 32'(flRst), 'h00);
        checkOutput("release_bank_q", 32'(flQ), 'h00);

        applyStimulus(2'b10, 8'hA5, lat, d, e, clkLow, setCnt);
        checkOutput("load_latency", 32'(lat), 'd8);
        checkOutput("load_clk_low", 32'(clkLow), 'd2);
        checkOutput("load_data", 32'(d), 'hA5);
        checkOutput("load_err", 32'(e), 'h0);

        applyStimulus(2'b01, 8'h0F, lat, d, e, clkLow, setCnt);
        checkOutput("preset_latency", 32'(lat), 'd4);
        checkOutput("preset_set_cycles", 32'(setCnt), 'd2);
        checkOutput("preset_data", 32'(d), 'hAF);
        checkOutput("preset_err", 32'(e), 'h0);

        applyStimulus(2'b00, 8'hF0, lat, d, e, clkLow, setCnt);
        checkOutput("clear_data", 32'(d), 'h0F);

        applyStimulus(2'b00, 8'h00, lat, d, e, clkLow, setCnt);
        checkOutput("clear0_latency", 32'(lat), 'd4);
        checkOutput("clear0_data", 32'(d), 'h0F);
        checkOutput("clear0_err", 32'(e), 'h0);

        @(negedge clk);
        stuck0 = 8'h08;
        applyStimulus(2'b10, 8'hFF, lat, d, e, clkLow, setCnt);
        checkOutput("stuck_load_data", 32'(d), 'hF7);
        checkOutput("stuck_load_err", 32'(e), 'h1);
        checkOutput("stuck_err_cnt", 32'(errCnt), 'h1);
        applyStimulus(2'b11, 8'h00, lat, d, e, clkLow, setCnt);
        checkOutput("read_latency", 32'(lat), 'd2);
        checkOutput("read_err", 32'(e), 'h0);
        checkOutput("read_err_cnt", 32'(errCnt), 'h1);

        @(negedge clk);
        rspReady = 1'b0;
        applyStimulus(2'b11, 8'h00, lat, held, e, clkLow, setCnt);
        repeat (5) begin
            @(posedge clk);
            #1;
            checkOutput("hold_rsp_valid", 32'(rspValid), 'h1);
            checkOutput("hold_rsp_data", 32'(rspData), 'hF7);
            checkOutput("hold_cmd_ready", 32'(cmdReady), 'h0);
        end
        @(negedge clk);
        rspReady = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("release_cmd_ready", 32'(cmdReady), 'h1);

        @(negedge clk);
        cmdValid = 1'b1;
        cmdOp = 2'b10;
        cmdData = 8'h3C;
        @(posedge clk);
        #1;
        cmdValid = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        checkOutput("fall_fl_clk", 32'(flClk), 'h0);
        #1 reset = 1'b1;
        #1;
        checkOutput("midreset_fl_clk", 32'(flClk), 'h1);
        checkOutput("midreset_fl_rst", 32'(flRst), 'hFF);
        checkOutput("midreset_fl_d", 32'(flD), 'h00);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            checkOutput("midreset_no_rsp", 32'(rspValid), 'h0);
        end
        applyStimulus(2'b11, 8'h00, lat, d, e, clkLow, setCnt);
        checkOutput("post_reset_read", 32'(d), 'h00);
        checkOutput("post_reset_err_cnt", 32'(errCnt), 'h0);

        for (int i = 0; i < 260; i++) begin
            applyStimulus(2'b01, 8'h08, lat, d, e, clkLow, setCnt);
        end
        checkOutput("sat_err", 32'(e), 'h1);
        checkOutput("sat_err_cnt", 32'(errCnt), 'hFF);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
